// File: rtl/comparator_4bit.sv
// Registered magnitude comparator slice in the style of the 7485.
// Produces lt/eq/gt one clock after a valid input. When the operands are
// equal, the decision falls through to the cascade inputs, so slices can be
// chained LSB-slice-first into a wider compare.
//
// Handshake: in_valid is a one-cycle qualifier with no back-pressure. Every
// edge with in_valid=1 loads one result. out_valid is high for exactly the
// cycle after that edge. lt/eq/gt keep their last value while no new input
// arrives.
module comparator_4bit #(
  parameter int WIDTH  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             lt_in,
  input  logic             eq_in,
  input  logic             gt_in,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic             out_valid
);

  // Operand scan results
  logic w_diff;     // some bit of a differs from b
  logic w_a_big;    // at the first differing bit, a is the larger operand

  // Next-state compare result
  logic w_lt;
  logic w_eq;
  logic w_gt;

  // Output registers
  logic r_lt;
  logic r_eq;
  logic r_gt;
  logic r_out_valid;

  // Find the first differing bit from the MSB. In a signed compare the MSB is
  // the sign bit, so a set bit there means the operand is smaller.
  always_comb begin
    w_diff  = 1'b0;
    w_a_big = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!w_diff && (a[i] != b[i])) begin
        w_diff  = 1'b1;
        w_a_big = (SIGNED && (i == WIDTH - 1)) ? b[i] : a[i];
      end
    end
  end

  // Resolve the final flags. Differing operands decide on their own and the
  // cascade is ignored. Equal operands defer to the lower-order slice,
  // including the two 7485 corner cases: lt_in=gt_in=1 gives all zeros, and
  // all-zero cascade gives lt=gt=1.
  always_comb begin
    w_lt = 1'b0;
    w_eq = 1'b0;
    w_gt = 1'b0;
    if (w_diff) begin
      w_gt = w_a_big;
      w_lt = ~w_a_big;
    end else if (eq_in) begin
      w_eq = 1'b1;
    end else if (lt_in && !gt_in) begin
      w_lt = 1'b1;
    end else if (gt_in && !lt_in) begin
      w_gt = 1'b1;
    end else if (lt_in && gt_in) begin
      w_lt = 1'b0;
      w_gt = 1'b0;
    end else begin
      w_lt = 1'b1;
      w_gt = 1'b1;
    end
  end

  // Capture the compare on a valid edge. Flags hold while idle, and reset
  // discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lt        <= 1'b0;
      r_eq        <= 1'b0;
      r_gt        <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_lt <= w_lt;
        r_eq <= w_eq;
        r_gt <= w_gt;
      end
    end
  end

  assign lt        = r_lt;
  assign eq        = r_eq;
  assign gt        = r_gt;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_comparator_4bit.sv
// Bench for comparator_4bit.
// Instances under test: an unsigned slice, a signed slice, and two chained
// unsigned slices that form an 8-bit compare.
module tb_comparator_4bit;

  logic clk;
  logic rst_n;

  int n_vec;
  int n_err;

  // Expected {lt,eq,gt} queues, one per checked instance
  logic [2:0] exp_q[$];
  logic [2:0] exp_s_q[$];
  logic [2:0] exp_c_q[$];

  // Unsigned instance
  logic       m_valid, m_lt_in, m_eq_in, m_gt_in;
  logic [3:0] m_a, m_b;
  logic       m_lt, m_eq, m_gt, m_out_valid;

  // Signed instance
  logic       s_valid;
  logic [3:0] s_a, s_b;
  logic       s_lt, s_eq, s_gt, s_out_valid;

  // Chained pair: low slice feeds the high slice's cascade inputs
  logic       lo_valid;
  logic [3:0] lo_a, lo_b, hi_a, hi_b;
  logic       lo_lt, lo_eq, lo_gt, lo_out_valid;
  logic       hi_lt, hi_eq, hi_gt, hi_out_valid;

  comparator_4bit #(.WIDTH(4), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(m_valid), .a(m_a), .b(m_b),
    .lt_in(m_lt_in), .eq_in(m_eq_in), .gt_in(m_gt_in),
    .lt(m_lt), .eq(m_eq), .gt(m_gt), .out_valid(m_out_valid)
  );

  comparator_4bit #(.WIDTH(4), .SIGNED(1'b1)) u_sdut (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .a(s_a), .b(s_b),
    .lt_in(1'b0), .eq_in(1'b1), .gt_in(1'b0),
    .lt(s_lt), .eq(s_eq), .gt(s_gt), .out_valid(s_out_valid)
  );

  comparator_4bit #(.WIDTH(4), .SIGNED(1'b0)) u_lo (
    .clk(clk), .rst_n(rst_n), .in_valid(lo_valid), .a(lo_a), .b(lo_b),
    .lt_in(1'b0), .eq_in(1'b1), .gt_in(1'b0),
    .lt(lo_lt), .eq(lo_eq), .gt(lo_gt), .out_valid(lo_out_valid)
  );

  comparator_4bit #(.WIDTH(4), .SIGNED(1'b0)) u_hi (
    .clk(clk), .rst_n(rst_n), .in_valid(lo_out_valid), .a(hi_a), .b(hi_b),
    .lt_in(lo_lt), .eq_in(lo_eq), .gt_in(lo_gt),
    .lt(hi_lt), .eq(hi_eq), .gt(hi_gt), .out_valid(hi_out_valid)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout, need summary before 200000");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b need %b", name, got, exp);
    end
  endtask

  // Monitors: pop one expectation per presented result
  always @(negedge clk) begin
    if (m_out_valid) begin
      if (exp_q.size() == 0) check("main_unexpected", {1'b0, m_lt, m_eq, m_gt}, 4'b1111);
      else check("main", {1'b0, m_lt, m_eq, m_gt}, {1'b0, exp_q.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (s_out_valid) begin
      if (exp_s_q.size() == 0) check("signed_unexpected", {1'b0, s_lt, s_eq, s_gt}, 4'b1111);
      else check("signed", {1'b0, s_lt, s_eq, s_gt}, {1'b0, exp_s_q.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (hi_out_valid) begin
      if (exp_c_q.size() == 0) check("chain_unexpected", {1'b0, hi_lt, hi_eq, hi_gt}, 4'b1111);
      else check("chain", {1'b0, hi_lt, hi_eq, hi_gt}, {1'b0, exp_c_q.pop_front()});
    end
  end

  // Driver tasks: called 1 time unit after a rising edge; they return
  // 1 time unit after the capturing edge.
  task automatic send(input logic [3:0] a, input logic [3:0] b,
                      input logic eqi, input logic lti, input logic gti,
                      input logic [2:0] exp);
    m_a = a; m_b = b; m_eq_in = eqi; m_lt_in = lti; m_gt_in = gti;
    m_valid = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
  endtask

  task automatic send_s(input logic [3:0] a, input logic [3:0] b, input logic [2:0] exp);
    s_a = a; s_b = b; s_valid = 1'b1;
    exp_s_q.push_back(exp);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic send_c(input logic [7:0] a, input logic [7:0] b, input logic [2:0] exp);
    lo_a = a[3:0]; lo_b = b[3:0]; lo_valid = 1'b1;
    exp_c_q.push_back(exp);
    @(posedge clk); #1;
    lo_valid = 1'b0;
    hi_a = a[7:4]; hi_b = b[7:4];
    @(posedge clk); #1;
  endtask

  // Stimulus: directed vectors, expected {lt,eq,gt} computed by hand
  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0;
    m_valid = 1'b0; m_a = '0; m_b = '0; m_eq_in = 1'b1; m_lt_in = 1'b0; m_gt_in = 1'b0;
    s_valid = 1'b0; s_a = '0; s_b = '0;
    lo_valid = 1'b0; lo_a = '0; lo_b = '0; hi_a = '0; hi_b = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", {m_out_valid, m_lt, m_eq, m_gt}, 4'b0000);
    rst_n = 1'b1;

    // Basic back-to-back sequence
    send(4'd0,  4'd0, 1'b1, 1'b0, 1'b0, 3'b010);
    send(4'd2,  4'd9, 1'b1, 1'b0, 1'b0, 3'b100);
    send(4'd14, 4'd9, 1'b1, 1'b0, 1'b0, 3'b001);
    send(4'd2,  4'd9, 1'b1, 1'b0, 1'b0, 3'b100);
    send(4'd0,  4'd0, 1'b1, 1'b0, 1'b0, 3'b010);
    send(4'd10, 4'd10, 1'b1, 1'b0, 1'b0, 3'b010);
    send(4'd13, 4'd9, 1'b1, 1'b0, 1'b0, 3'b001);

    // Hold: no new load while in_valid is low
    m_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_a = 4'(i); m_b = 4'(15 - i);
      @(posedge clk); #1;
      check("hold", {m_out_valid, m_lt, m_eq, m_gt}, 4'b0001);
    end

    // Cascade resolution when a == b, plus cascade ignored when a != b
    send(4'd5, 4'd5, 1'b0, 1'b1, 1'b0, 3'b100);
    send(4'd5, 4'd5, 1'b0, 1'b0, 1'b1, 3'b001);
    send(4'd5, 4'd5, 1'b0, 1'b0, 1'b0, 3'b101);
    send(4'd5, 4'd5, 1'b0, 1'b1, 1'b1, 3'b000);
    send(4'd5, 4'd5, 1'b1, 1'b1, 1'b1, 3'b010);
    send(4'd6, 4'd5, 1'b0, 1'b1, 1'b0, 3'b001);
    send(4'd4, 4'd5, 1'b0, 1'b0, 1'b1, 3'b100);
    // Unsigned extremes
    send(4'd8,  4'd7, 1'b1, 1'b0, 1'b0, 3'b001);
    send(4'd15, 4'd0, 1'b1, 1'b0, 1'b0, 3'b001);
    send(4'd14, 4'd9, 1'b1, 1'b0, 1'b0, 3'b001);
    m_valid = 1'b0;

    // Asynchronous reset while out_valid and gt are high
    #6;
    rst_n = 1'b0;
    #1;
    check("async_reset", {m_out_valid, m_lt, m_eq, m_gt}, 4'b0000);
    @(posedge clk); #1;
    check("reset_held", {m_out_valid, m_lt, m_eq, m_gt}, 4'b0000);
    rst_n = 1'b1;
    send(4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 3'b010);
    m_valid = 1'b0;

    // Signed compares
    send_s(4'b1000, 4'b0111, 3'b100);
    send_s(4'b1111, 4'b1110, 3'b001);
    send_s(4'b0111, 4'b1000, 3'b001);
    send_s(4'b0000, 4'b1111, 3'b001);
    send_s(4'b1010, 4'b1010, 3'b010);

    // 8-bit chain
    send_c(8'h3A, 8'h3B, 3'b100);
    send_c(8'h5C, 8'h5C, 3'b010);
    send_c(8'h4A, 8'h3F, 3'b001);
    send_c(8'h3F, 8'h3E, 3'b001);

    // Drain: every pushed expectation must have been consumed
    repeat (4) @(posedge clk);
    #1;
    check("drain_main",   4'(exp_q.size()),   4'd0);
    check("drain_signed", 4'(exp_s_q.size()), 4'd0);
    check("drain_chain",  4'(exp_c_q.size()), 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
